// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if
//   Bundles the instruction-memory request/response channel and the IF/ID
//   valid/ready channel of the fetch stage.
//   master : the fetch stage (drives request, IF/ID entry)
//   slave  : the memory/decode side (drives ready, response, decode ready)
//   Signals:
//     imem_req_valid / imem_req_ready / imem_addr  fetch request
//     imem_rsp_valid / imem_rsp_data               fetch response (1-cycle strobe)
//     id_valid / id_ready / id_pc / id_instr       IF/ID head entry
interface if_fetch_stage_if #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
);
  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               id_valid;
  logic               id_ready;
  logic [ADDR_W-1:0]  id_pc;
  logic [INSTR_W-1:0] id_instr;

  modport master (
    output imem_req_valid, imem_addr, id_valid, id_pc, id_instr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, id_valid, id_pc, id_instr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready
  );
endinterface

// File: rtl/if_fetch_stage.sv
// if_fetch_stage
//   Instruction fetch stage sitting behind the PC stage. Latches the current
//   PC into a registered memory request, buffers returned words in a small
//   IF/ID FIFO and hands {pc, instr} pairs to decode. A flush (redirect)
//   discards the FIFO and any in-flight fetch.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   pc           current PC from the PC stage
//   pc_advance   1-cycle pulse when the fetch at pc is accepted by memory
//   flush        redirect/squash
//   bus          if_fetch_stage_if.master (imem request/response, IF/ID)
// Optional build macro IF_PERF_CNT_EN adds saturating counters:
//   perf_fetch_cnt  committed FIFO pushes
//   perf_stall_cnt  cycles with id_valid=0 and no flush
//
// state | meaning
// IDLE  | no request; issue once a FIFO slot is free
// REQ   | request on imem port, address held until accepted
// WAIT  | request accepted, waiting for the response strobe
module if_fetch_stage #(
  parameter int ADDR_W     = 64,
  parameter int INSTR_W    = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_advance,
  input  logic              flush,
  if_fetch_stage_if.master  bus
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = ADDR_W + INSTR_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  addr_q, addr_nxt;
  logic               drop, drop_nxt;
  logic               push, pop;

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [ENTRY_W-1:0] head;

  // A new fetch is only started from IDLE, where nothing is outstanding, so
  // a free FIFO slot is enough to reserve room for its response.
  always_comb begin
    state_nxt  = state;
    addr_nxt   = addr_q;
    drop_nxt   = drop;
    push       = 1'b0;
    pc_advance = 1'b0;
    unique case (state)
      IDLE: begin
        if (!flush && (count < DEPTH_C)) begin
          state_nxt = REQ;
          addr_nxt  = pc;
        end
      end
      REQ: begin
        if (bus.imem_req_ready) begin
          // accepted request is committed; a flush only marks it for discard
          state_nxt  = WAIT;
          pc_advance = !flush;
          drop_nxt   = flush;
        end else if (flush) begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (bus.imem_rsp_valid) begin
          push      = !drop && !flush;
          drop_nxt  = 1'b0;
          state_nxt = IDLE;
        end else if (flush) begin
          drop_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign pop = bus.id_valid && bus.id_ready && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      addr_q <= '0;
      drop   <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state  <= state_nxt;
      addr_q <= addr_nxt;
      drop   <= drop_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Storage needs no reset: head outputs are gated by id_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {addr_q, bus.imem_rsp_data};
  end

  assign head               = mem[rd_ptr];
  assign bus.imem_req_valid = (state == REQ);
  assign bus.imem_addr      = addr_q;
  assign bus.id_valid       = (count != '0);
  assign bus.id_pc          = bus.id_valid ? head[ENTRY_W-1:INSTR_W] : '0;
  assign bus.id_instr       = bus.id_valid ? head[INSTR_W-1:0] : '0;

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (push && (perf_fetch_cnt != '1))
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (!bus.id_valid && !flush && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage
//   Directed scenarios followed by a randomized phase. The bench plays the PC
//   stage (steps pc by 8 on pc_advance, jumps on flush), the instruction
//   memory (instr = instr_of(addr), random ready/latency, spurious response
//   strobes while no request is outstanding) and decode. The reference model
//   is the architectural rule that decode sees consecutive PCs starting from
//   the last redirect target, each paired with instr_of(pc).
module tb_if_fetch_stage;
  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;
  localparam logic [63:0] STEP = 64'd8;
  localparam logic [31:0] BAD  = 32'hDEAD_BEEF;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic [63:0]       pc    = '0;
  logic              pc_advance;
  logic              flush = 1'b0;

  if_fetch_stage_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  if_fetch_stage #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .FIFO_DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc         (pc),
    .pc_advance (pc_advance),
    .flush      (flush),
    .bus        (bus)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;

  // environment knobs
  bit          rdy_rand = 1'b0;
  logic        rdy_val  = 1'b1;
  bit          dec_rand = 1'b0;
  logic        dec_val  = 1'b1;
  int          lat_knob = 1;      // 0: random 1..3
  bit          noise_on = 1'b1;
  bit          use_bad  = 1'b0;
  bit          flush_req = 1'b0;
  logic [63:0] flush_tgt = '0;

  // model / monitor state
  logic [63:0] exp_pc = '0;
  logic [63:0] last_pop_pc = '0;
  int          pop_cnt = 0;
  int          adv_cnt = 0;
  int          cyc = 0;
  bit          saw_bad = 1'b0;
  bit          pending = 1'b0;
  int          rsp_cnt = 0;
  logic [63:0] rsp_addr = '0;

  function automatic logic [31:0] instr_of(logic [63:0] a);
    return (a[34:3] * 32'h9E37_79B1) + 32'h1357_9BDF;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // PC stage, instruction memory and decode
  initial begin
    bit s_flush, s_adv;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.id_ready       = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      s_flush = 1'b0;
      s_adv   = 1'b0;
      if (!rst_n) begin
        pending = 1'b0;
      end else begin
        s_flush = flush;
        s_adv   = pc_advance;
        chk("adv_during_flush", 64'(flush & pc_advance), 64'd0);
        if (pc_advance) begin
          adv_cnt++;
          chk("adv_addr", bus.imem_addr, pc);
        end
        if (bus.id_valid && bus.id_instr === BAD) saw_bad = 1'b1;
        if (flush) begin
          exp_pc = flush_tgt;
        end else if (bus.id_valid && bus.id_ready) begin
          chk("id_pc", bus.id_pc, exp_pc);
          chk("id_instr", 64'(bus.id_instr), 64'(instr_of(exp_pc)));
          last_pop_pc = bus.id_pc;
          exp_pc += STEP;
          pop_cnt++;
        end
        if (bus.imem_req_valid && bus.imem_req_ready) begin
          pending  = 1'b1;
          rsp_addr = bus.imem_addr;
          rsp_cnt  = (lat_knob == 0) ? int'($urandom_range(1, 3)) : lat_knob;
        end
      end
      @(posedge clk);
      #1;
      if (s_flush)    pc = flush_tgt;
      else if (s_adv) pc = pc + STEP;
      flush     = flush_req;
      flush_req = 1'b0;
      bus.imem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
      bus.id_ready       = dec_rand ? 1'($urandom_range(0, 1)) : dec_val;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      if (pending) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          bus.imem_rsp_valid = 1'b1;
          bus.imem_rsp_data  = use_bad ? BAD : instr_of(rsp_addr);
          use_bad = 1'b0;
          pending = 1'b0;
        end
      end else if (noise_on) begin
        bus.imem_rsp_valid = 1'($urandom_range(0, 1));
        bus.imem_rsp_data  = $urandom;
      end
    end
  end

  // one-cycle flush applied at the next cycle boundary
  task automatic redirect(logic [63:0] tgt);
    flush_tgt = tgt;
    flush_req = 1'b1;
    @(negedge clk);
    #1;
  endtask

  initial begin
    int          pop_cyc[$];
    int          seen, a0, p0, hi_cnt;
    bit          got;
    logic [63:0] t;
`ifdef IF_PERF_CNT_EN
    logic [31:0] f0;
`endif

    // reset with memory stimulus active
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
      chk("rst_pc_advance", 64'(pc_advance), 64'd0);
      chk("rst_id_valid", 64'(bus.id_valid), 64'd0);
    end
    rst_n = 1'b1;

    // back-to-back fetch: one instruction per 3 cycles
    seen = 0;
    for (int i = 0; i < 40 && pop_cnt < 3; i++) begin
      @(negedge clk);
      #1;
      if (pop_cnt > seen) begin
        pop_cyc.push_back(cyc);
        seen = pop_cnt;
      end
    end
    chk("s2_pops", 64'(pop_cnt), 64'd3);
    if (pop_cyc.size() == 3) begin
      chk("s2_gap1", 64'(pop_cyc[1] - pop_cyc[0]), 64'd3);
      chk("s2_gap2", 64'(pop_cyc[2] - pop_cyc[1]), 64'd3);
    end
    chk("s2_adv_cnt", 64'(adv_cnt), 64'd3);
`ifdef IF_PERF_CNT_EN
    chk("s6_perf_fetch", 64'(perf_fetch_cnt), 64'd3);
`endif

    // memory not ready for 3 cycles: request held stable
    rdy_val = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("s5_req_valid", 64'(bus.imem_req_valid), 64'd1);
      chk("s5_addr", bus.imem_addr, 64'd24);
      chk("s5_no_adv", 64'(pc_advance), 64'd0);
    end
    rdy_val = 1'b1;
    @(negedge clk);
    #1;
    chk("s5_adv_pulse", 64'(pc_advance), 64'd1);
    chk("s5_adv_cnt", 64'(adv_cnt), 64'd4);
    @(negedge clk);
    #1;
    chk("s5_adv_once", 64'(pc_advance), 64'd0);

    // decode stalled: two entries buffered, fetching stops
    dec_val = 1'b0;
    redirect(64'd0);
    @(negedge clk);
    #1;
    chk("s3_flush_empty", 64'(bus.id_valid), 64'd0);
    a0 = adv_cnt;
    p0 = pop_cnt;
    repeat (25) @(negedge clk);
    #1;
    chk("s3_adv_delta", 64'(adv_cnt - a0), 64'd2);
    chk("s3_id_valid", 64'(bus.id_valid), 64'd1);
    chk("s3_head_pc", bus.id_pc, 64'd0);
    hi_cnt = 0;
    repeat (5) begin
      @(negedge clk);
      #1;
      if (bus.imem_req_valid) hi_cnt++;
    end
    chk("s3_req_held_off", 64'(hi_cnt), 64'd0);
    dec_val = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      #1;
      got = pc_advance;
    end
    chk("s3_resume_seen", 64'(got), 64'd1);
    chk("s3_resume_addr", bus.imem_addr, 64'd16);
    chk("s3_drained", 64'(pop_cnt - p0), 64'd2);

    // flush while waiting; the late response must be discarded
    lat_knob = 3;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      #1;
      got = pending && (rsp_cnt == 3);
    end
    chk("s4_wait_seen", 64'(got), 64'd1);
    use_bad = 1'b1;
    redirect(64'h100);
    @(negedge clk);
    #1;
    chk("s4_flush_empty", 64'(bus.id_valid), 64'd0);
    p0 = pop_cnt;
    for (int i = 0; i < 40 && pop_cnt == p0; i++) begin
      @(negedge clk);
      #1;
    end
    chk("s4_redirect_pc", last_pop_pc, 64'h100);

    // flush in the same cycle as the response
    lat_knob = 1;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      #1;
      got = pending && (rsp_cnt == 1);
    end
    chk("s6_wait_seen", 64'(got), 64'd1);
`ifdef IF_PERF_CNT_EN
    f0 = perf_fetch_cnt;
`endif
    redirect(64'h200);
    @(negedge clk);
    #1;
    chk("s6_flush_empty", 64'(bus.id_valid), 64'd0);
`ifdef IF_PERF_CNT_EN
    chk("s6_perf_unchanged", 64'(perf_fetch_cnt), 64'(f0));
`endif
    p0 = pop_cnt;
    for (int i = 0; i < 40 && pop_cnt == p0; i++) begin
      @(negedge clk);
      #1;
    end
    chk("s6_redirect_pc", last_pop_pc, 64'h200);

    // randomized traffic with occasional redirects
    rdy_rand = 1'b1;
    dec_rand = 1'b1;
    lat_knob = 0;
    p0 = pop_cnt;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      if ($urandom_range(0, 39) == 0) begin
        t = {$urandom, $urandom} & ~64'h7;
        if ($urandom_range(0, 1) == 1) t = 64'($urandom_range(0, 65535)) << 3;
        redirect(t);
      end
    end
    chk("rand_progress", 64'(pop_cnt - p0 > 100), 64'd1);
    chk("never_bad_instr", 64'(saw_bad), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
